// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the pipeline writeback, secondary result, regfile write port and interlock query signals
// that pass between the core and the register-file write arbiter.
interface regfile_wb_arbiter_if;
    logic        p_we;
    logic [4:0]  p_wn;
    logic [31:0] p_d;
    logic        s_valid;
    logic [4:0]  s_wn;
    logic [31:0] s_d;
    logic        s_ready;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] d;
    logic        stall;
    logic [4:0]  qa_rn;
    logic [4:0]  qb_rn;
    logic        qa_pend;
    logic        qb_pend;

    modport master (
        output p_we, p_wn, p_d, s_valid, s_wn, s_d, qa_rn, qb_rn,
        input  s_ready, we, wn, d, stall, qa_pend, qb_pend
    );

    modport slave (
        input  p_we, p_wn, p_d, s_valid, s_wn, s_d, qa_rn, qb_rn,
        output s_ready, we, wn, d, stall, qa_pend, qb_pend
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between the primary writeback and a FIFO-buffered secondary unit.
// It applies WAW kills, reports pending registers, and stalls the pipeline when a buffered result starves.
module regfile_wb_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned STARVE = 4
) (
    input logic                 clk,
    input logic                 clrn,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(STARVE + 1);

    typedef struct packed {
        logic [4:0]  wn;
        logic [31:0] d;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] live;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    cnt;

    logic empty;
    logic head_live;
    logic starve;
    logic pg;
    logic pop;
    logic ready;
    logic push;

    // A non-empty head that is not live is a killed entry; it pops without writing.
    always_comb begin
        empty     = (count == '0);
        head_live = !empty && live[rd_ptr];
        starve    = clrn && head_live && (cnt == SW'(STARVE));
        pg        = clrn && bus.p_we && (bus.p_wn != 5'd0) && !starve;
        pop       = clrn && !empty && (!head_live || !pg);
        ready     = clrn && (count < CW'(DEPTH));
        push      = bus.s_valid && ready && (bus.s_wn != 5'd0);
    end

    always_comb begin
        bus.s_ready = ready;
        bus.stall   = starve;
        bus.we      = pg || (pop && head_live);
        bus.wn      = pg ? bus.p_wn : mem[rd_ptr].wn;
        bus.d       = pg ? bus.p_d  : mem[rd_ptr].d;
        bus.qa_pend = 1'b0;
        bus.qb_pend = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (live[i] && (mem[i].wn == bus.qa_rn)) bus.qa_pend = 1'b1;
            if (live[i] && (mem[i].wn == bus.qb_rn)) bus.qb_pend = 1'b1;
        end
        if (!clrn || (bus.qa_rn == 5'd0)) bus.qa_pend = 1'b0;
        if (!clrn || (bus.qb_rn == 5'd0)) bus.qb_pend = 1'b0;
    end

    // Kill first, then pop, then push: a same-cycle push to the killed register stays live.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            live   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (pg && live[i] && (mem[i].wn == bus.p_wn)) live[i] <= 1'b0;
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PW'(1);
            end
            if (push) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
            if (empty || pop) begin
                cnt <= '0;
            end else if (pg && head_live && (cnt != SW'(STARVE))) begin
                cnt <= cnt + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{wn: bus.s_wn, d: bus.s_d};
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle vector table for the combinational outputs,
// plus a write scoreboard that checks every regfile write in order.
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic clrn;
    int   checks = 0;
    int   errors = 0;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.DEPTH(2), .STARVE(4)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clrn;
        logic        p_we;
        logic [4:0]  p_wn;
        logic [31:0] p_d;
        logic        s_valid;
        logic [4:0]  s_wn;
        logic [31:0] s_d;
        logic [4:0]  qa_rn;
        logic [4:0]  qb_rn;
        logic        e_we;
        logic [4:0]  e_wn;
        logic [31:0] e_d;
        logic        e_sr;
        logic        e_st;
        logic        e_qa;
        logic        e_qb;
    } vec_t;

    logic [36:0] exp_q [$];
    logic [31:0] regs [32] = '{default: '0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Scoreboard: every write the DUT makes must match the next expected write.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_wn", 32'(bus.wn), 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("write_wn", 32'(bus.wn), 32'(e[36:32]));
                chk("write_d", bus.d, e[31:0]);
            end
        end
    end

    always @(posedge clk) begin
        if (bus.we === 1'b1) regs[bus.wn] <= bus.d;
    end

    function automatic vec_t mk(input int c, input int pwe, input int pwn, input logic [31:0] pd,
                                input int sv, input int swn, input logic [31:0] sd,
                                input int qa, input int qb,
                                input int we, input int wn, input logic [31:0] d,
                                input int sr, input int st, input int qap, input int qbp);
        vec_t v;
        v.clrn = 1'(c);    v.p_we = 1'(pwe);  v.p_wn = 5'(pwn);  v.p_d = pd;
        v.s_valid = 1'(sv); v.s_wn = 5'(swn); v.s_d = sd;
        v.qa_rn = 5'(qa);  v.qb_rn = 5'(qb);
        v.e_we = 1'(we);   v.e_wn = 5'(wn);   v.e_d = d;
        v.e_sr = 1'(sr);   v.e_st = 1'(st);   v.e_qa = 1'(qap);  v.e_qb = 1'(qbp);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        clrn = v.clrn;
        bus.p_we = v.p_we;   bus.p_wn = v.p_wn;   bus.p_d = v.p_d;
        bus.s_valid = v.s_valid; bus.s_wn = v.s_wn; bus.s_d = v.s_d;
        bus.qa_rn = v.qa_rn; bus.qb_rn = v.qb_rn;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v);
        if (v.e_we) exp_q.push_back({v.e_wn, v.e_d});
        @(negedge clk);
        chk($sformatf("v%0d_we", idx),      32'(bus.we),      32'(v.e_we));
        chk($sformatf("v%0d_s_ready", idx), 32'(bus.s_ready), 32'(v.e_sr));
        chk($sformatf("v%0d_stall", idx),   32'(bus.stall),   32'(v.e_st));
        chk($sformatf("v%0d_qa_pend", idx), 32'(bus.qa_pend), 32'(v.e_qa));
        chk($sformatf("v%0d_qb_pend", idx), 32'(bus.qb_pend), 32'(v.e_qb));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl [$];
        vec_t idle;
        int   k;
        int   stall_at;

        //           c pwe pwn pd            sv swn sd           qa  qb  we wn  d             sr st qa qb
        tbl.push_back(mk(0, 1, 5, 32'h1,        1, 3,  32'h3,        3,  0,  0, 0,  32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0,  32'h0,        0,  0,  1, 5,  32'hDEADBEEF, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 32'h123,      0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 3,  32'h11,       3,  0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 4,  32'h22,       3,  4,  1, 3,  32'h11,       1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,        3,  4,  1, 4,  32'h22,       1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 32'h1,        1, 10, 32'hA0,       0,  0,  1, 1,  32'h1,        1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h2,        1, 11, 32'hB0,       0,  0,  1, 1,  32'h2,        1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h3,        1, 12, 32'hC0,       10, 12, 1, 1,  32'h3,        0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 12, 32'hC0,       11, 0,  1, 10, 32'hA0,       0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,        0,  0,  1, 11, 32'hB0,       1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 7,  32'hAA,       7,  0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 7, 32'hBB,       0, 0,  32'h0,        7,  0,  1, 7,  32'hBB,       1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,        7,  0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,        7,  0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 9,  32'h99,       9,  0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h101,      0, 0,  32'h0,        9,  0,  1, 1,  32'h101,      1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 32'h102,      0, 0,  32'h0,        9,  0,  1, 1,  32'h102,      1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 32'h103,      0, 0,  32'h0,        9,  0,  1, 1,  32'h103,      1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 32'h104,      0, 0,  32'h0,        9,  0,  1, 1,  32'h104,      1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 32'h105,      0, 0,  32'h0,        9,  0,  1, 9,  32'h99,       1, 1, 1, 0));
        tbl.push_back(mk(1, 1, 1, 32'h106,      0, 0,  32'h0,        9,  0,  1, 1,  32'h106,      1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 0,  32'h55,       0,  0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h7,        1, 13, 32'hD0,       0,  13, 1, 1,  32'h7,        1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h8,        1, 14, 32'hE0,       0,  13, 1, 1,  32'h8,        1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 32'h9,        0, 0,  32'h0,        13, 14, 0, 0,  32'h0,        0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 15, 32'hF0,       13, 14, 0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,        15, 0,  1, 15, 32'hF0,       1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,        15, 0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        1, 21, 32'h1,        0,  0,  0, 0,  32'h0,        1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 21, 32'h2,       0, 0,  32'h0,        21, 0,  1, 21, 32'h2,        1, 0, 1, 0));
        tbl.push_back(mk(1, 1, 22, 32'h3,       0, 0,  32'h0,        21, 0,  1, 22, 32'h3,        1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0,  32'h0,        0,  0,  0, 0,  32'h0,        1, 0, 0, 0));

        idle = mk(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0);

        drive(tbl[0]);
        repeat (2) @(posedge clk);
        #1;

        foreach (tbl[i]) apply(tbl[i], i);

        // Starvation with a bounded wait: r20 buffered behind a continuously busy primary.
        drive(idle);
        bus.s_valid = 1'b1; bus.s_wn = 5'd20; bus.s_d = 32'h20;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        stall_at = 0;
        k = 0;
        while (stall_at == 0 && k < 8) begin
            k++;
            bus.p_we = 1'b1; bus.p_wn = 5'd2; bus.p_d = 32'(k);
            if (k == 5) exp_q.push_back({5'd20, 32'h20});
            else        exp_q.push_back({5'd2, 32'(k)});
            @(negedge clk);
            if (bus.stall === 1'b1) stall_at = k;
            @(posedge clk);
            #1;
        end
        chk("starve_stall_cycle", 32'(stall_at), 32'd5);
        drive(idle);
        repeat (3) @(posedge clk);
        #1;

        chk("r7_final", regs[7], 32'hBB);
        chk("r12_refused", regs[12], 32'h0);
        chk("r13_lost_in_reset", regs[13], 32'h0);
        chk("r14_lost_in_reset", regs[14], 32'h0);
        chk("r20_drained", regs[20], 32'h20);
        chk("missing_writes", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32x32 integer register file between the in-order pipeline writeback (primary) and a multi-cycle unit such as the FPU or divider (secondary). Primary writes pass straight through. Secondary results are buffered in a small FIFO and drained on idle write-port cycles. The block enforces write-after-write ordering, reports pending registers to the interlock logic, and forces a pipeline stall when a buffered result has been starved too long.

## Interface
Parameters:
- DEPTH, 2: secondary FIFO entries (power of two, at least 2).
- STARVE, 4: number of consecutive primary-taken cycles with a non-empty FIFO before `stall` is raised (at least 1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  reset, synchronous, active-low.
- p_we  in  1  primary write request.
- p_wn  in  5  primary destination register.
- p_d  in  32  primary write data.
- s_valid  in  1  secondary result valid.
- s_wn  in  5  secondary destination register.
- s_d  in  32  secondary data.
- s_ready  out  1  secondary accept; a transfer occurs when s_valid and s_ready are both high.
- we  out  1  regfile write enable.
- wn  out  5  regfile write register.
- d  out  32  regfile write data.
- stall  out  1  pipeline must hold; primary inputs are ignored this cycle and re-presented later.
- qa_rn, qb_rn  in  5 each  interlock query register numbers.
- qa_pend, qb_pend  out  1 each  query hit on a live buffered entry.

## Operation
- FIFO entry fields: live bit, wn, d. Pointers are log2(DEPTH) bits and wrap. Occupancy is a separate counter with range 0..DEPTH.
- `s_ready` = (count < DEPTH) and clrn. A pop in the same cycle does not raise `s_ready`.
- A secondary transfer with s_wn = 0 is accepted and discarded; nothing is enqueued.
- Primary grant (pg) = p_we and p_wn != 0 and !stall. When pg is high: we=1, wn=p_wn, d=p_d.
- Head pop occurs in either of two cases:
  - The head is dead: it pops regardless of pg, and we is not driven by it.
  - The head is live and !pg: we=1, wn/d taken from the head.
- Otherwise we=0, and wn/d are don't-care (they are driven from the head).
- WAW kill: on pg, every stored live entry with wn == p_wn is cleared at the edge. Primary writes are always program-order younger than stored entries. A secondary entry accepted in the same cycle as a primary write to the same register is treated as younger: it is enqueued live.
- Starvation counter `cnt` (0..STARVE):
  - Cleared when the FIFO is empty or on any pop.
  - Otherwise incremented when pg is high with a live head.
  - `stall` = (cnt == STARVE) and the head is live. A stall cycle always pops the head, so `stall` lasts exactly one cycle.
- qa_pend = (qa_rn != 0) and some stored live entry has wn == qa_rn. qb_pend is the same for qb_rn. Only registered entries are checked; the same-cycle incoming s_* is not.
- Simultaneous push and pop on a full FIFO: the pop proceeds, the push is refused (`s_ready` is low).

## Timing
- Primary path is combinational, zero latency: the regfile is written at the end of the same cycle.
- Secondary result accepted at edge E reaches the head no earlier than cycle E+1. It is written to the regfile at the end of that cycle if the port is free.
- `s_ready`, `stall`, `we`, and the query outputs are combinational from registered state plus p_* and q*_rn inputs. There is no path from s_* to any output.
- Reset: a low clrn sampled at an edge empties the FIFO, clears all live bits and pointers, and sets cnt=0.
- While clrn is low, outputs are forced: we=0, s_ready=0, stall=0, qa_pend=qb_pend=0. This also applies to a reset asserted mid-drain; in-flight entries are lost.
- After clrn returns high, the first accept is possible in the same cycle.

## Test plan
- Primary only: p_we=1, p_wn=5, p_d=0xDEADBEEF -> same-cycle we=1, wn=5, d=0xDEADBEEF. p_wn=0 -> we=0.
- Secondary drain, DEPTH=2: push r3=0x11 then r4=0x22 with primary idle -> writes r3 then r4 on consecutive cycles. With two stored entries and no pop, `s_ready` is low and a third push is refused.
- WAW kill: push r7=0xAA, then the primary writes r7=0xBB while the entry is buffered -> the entry dies and qa_pend(rn=7) drops to 0. The dead head pops without asserting we. r7 final value is 0xBB.
- Starvation, STARVE=4: one buffered r9, primary writes r1 for 6 consecutive cycles -> `stall`=1 in cycle 5 only, we=1 with wn=9 that cycle, p_* ignored.
- Query/zero: push s_wn=0 -> accepted, count unchanged. qa_rn=0 -> qa_pend=0 even with entries live.
- Reset mid-operation: two entries buffered, clrn=0 for one edge -> FIFO empty, no write of either entry, s_ready=0 during reset, s_ready=1 in the cycle after release.
